dwc_pcie_axi_slv_rs: RTL and testbench
======================================

# dwc_pcie_axi_slv_rs

Parametrised AXI slave-port register slice: the successor to the AXI slave sideband pass-through. It sits between the AXI slave bus interface and the slave core, on all five AXI channels (AW, AR, W, R, B). Each channel is independently configurable as bypass, forward-registered, or a full two-entry skid buffer. The slice also reports an idle flag for clock-gating and low-power entry.

## Interface
Parameters:
- AW_PYLD_WIDTH, 64: packed AW payload width (address, id, len, size, burst, prot, user, parity).
- AR_PYLD_WIDTH, 64: packed AR payload width.
- W_PYLD_WIDTH, 145: packed W payload width (data, strb, last, user, parity).
- R_PYLD_WIDTH, 140: packed R payload width (data, id, resp, last, user, parity).
- B_PYLD_WIDTH, 12: packed B payload width (id, resp, user).
- AW_MODE / AR_MODE / W_MODE / R_MODE / B_MODE, 2: per-channel mode. 0 = bypass, 1 = forward register, 2 = full skid slice. Values 3 and above are illegal and fail elaboration.

Ports (X = aw, ar, w, r, b; P = matching *_PYLD_WIDTH). "in" is the channel source side and "out" the sink side. For AW/AR/W the source is the bus and the sink is the core; for R/B the source is the core and the sink is the bus.
- slv_aclk  input  1  clock. One clock domain.
- slv_arstn  input  1  reset, asynchronous assert, active-low.
- in_X_valid  input  1  source valid.
- in_X_pyld  input  P  source payload.
- in_X_ready  output  1  ready to source.
- out_X_valid  output  1  valid to sink.
- out_X_pyld  output  P  payload to sink.
- out_X_ready  input  1  sink ready.
- slice_idle  output  1  high when no channel holds a buffered beat.

## Operation
- A transfer on either side occurs on a rising edge with valid && ready.
- Channels are fully independent. The slice never reorders, drops or duplicates beats.

Mode 0:
- out_valid = in_valid, out_pyld = in_pyld, in_ready = out_ready. All paths combinational, no storage.
- The channel contributes 1 to slice_idle.

Mode 1, one data register plus a valid flop:
- in_ready = !out_valid || out_ready. The ready path is combinational.
- On an input transfer, the register loads in_pyld and out_valid is set.
- On an output transfer with no input transfer, out_valid clears.
- Simultaneous input and output transfer: the register reloads and out_valid stays 1.

Mode 2, main register plus skid register, with registered in_ready. No combinational path in either direction.
- States: EMPTY (0 beats), ONE (main valid), FULL (main and skid valid).
- EMPTY -> ONE on an input transfer.
- ONE -> EMPTY on an output transfer with no input transfer.
- ONE -> FULL on an input transfer with no output transfer. The beat lands in skid.
- ONE -> ONE when input and output transfer in the same cycle. Main reloads.
- FULL -> ONE on an output transfer. Skid moves to main. No input transfer is possible in FULL.
- in_ready = (state != FULL). out_valid = (state != EMPTY). out_pyld = main register.

General rules:
- slice_idle = AND over channels of "channel empty". Mode 1 is empty when out_valid = 0; mode 2 is empty in EMPTY.
- Payload registers have no reset. Only valid/state/ready flops reset.
- Protocol invariant: while out_valid && !out_ready, out_pyld stays stable and out_valid stays high.

## Timing
Reset values (slv_arstn low), applied asynchronously:
- Mode 1/2: out_X_valid = 0. State = EMPTY.
- in_X_ready: 1 in mode 2; in mode 1 it is 1 because out_valid = 0.
- slice_idle = 1.
- out_X_pyld is undefined but must not be consumed, since valid = 0.

Latency and throughput:
- Mode 0: 0 cycles.
- Modes 1/2: 1 cycle, in_valid at edge N gives out_valid from edge N+1.
- Mode 1/2 sustain 1 beat per cycle when the sink holds ready high.
- Mode 2 under backpressure: absorbs exactly one extra beat after out_ready drops, then in_ready falls on the following edge.

Boundary cases:
- Reset asserted mid-burst: all buffered beats are discarded and the channel returns to EMPTY with no glitch on out_valid.
- Deassertion is used synchronously: no transfer is accepted on the edge at which slv_arstn rises.
- in_valid without ready in mode 2 FULL: the source holds. The slice must not sample in_pyld.
- Mode 2 FULL plus output transfer: the skid beat is presented on the next cycle. in_ready rises on the same edge.

## Test plan
- Reset: drive all in_valid = 1 during reset. Required: every out_valid = 0, slice_idle = 1, in_ready = 1 in modes 1/2; no transfer counted at the release edge.
- Streaming, mode 2, out_ready = 1: 16 W beats with payload 0..15. Required: out beats 0..15 in order, one per cycle, first beat one cycle after the first input; slice_idle = 0 throughout.
- Backpressure, mode 2: out_ready = 0 at cycle 3 of a stream of 0x10..0x1F, held for 4 cycles. Required: main = 0x12, skid = 0x13, in_ready low from cycle 4, no loss; after release, outputs 0x12, 0x13, 0x14... contiguous.
- Mode 1 simultaneous transfer: register holds 0xA, in_valid with 0xB and out_ready both 1. Required: 0xA accepted downstream, 0xB presented next cycle, out_valid never drops.
- Bypass, mode 0 on B: random valid/ready toggling for 200 cycles. Required: out = in in the same cycle, count of in transfers = count of out transfers, in_ready = out_ready each cycle.
- Reset mid-operation: FULL AR slice (beats 0x5, 0x6), assert slv_arstn low asynchronously between edges. Required: out_ar_valid = 0 immediately, state EMPTY, neither beat emitted after release.

Source files
------------

// File: rtl/dwc_pcie_axi_slv_rs.sv
// dwc_pcie_axi_slv_rs: per-channel AXI slave-port register slice (bypass, forward register or two-entry skid)
// with an idle flag covering all five channels.

module dwc_pcie_axi_slv_rs_ch #(
   parameter int WIDTH = 64,
   parameter int MODE  = 2
) (
   input  logic             slv_aclk,
   input  logic             slv_arstn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_pyld,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pyld,
   input  logic             out_ready,
   output logic             idle
);
   if (MODE == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_pyld  = in_pyld;
      assign in_ready  = out_ready;
      assign idle      = 1'b1;
   end else if (MODE == 1) begin : g_fwd
      logic             vld_q;
      logic [WIDTH-1:0] data_q;
      logic             in_xfer;
      assign in_ready  = !vld_q || out_ready;
      assign in_xfer   = in_valid && in_ready;
      assign out_valid = vld_q;
      assign out_pyld  = data_q;
      assign idle      = !vld_q;
      always_ff @(posedge slv_aclk or negedge slv_arstn)
         if (!slv_arstn) vld_q <= 1'b0;
         else vld_q <= in_xfer ? 1'b1 : (out_ready ? 1'b0 : vld_q);
      always_ff @(posedge slv_aclk)
         if (in_xfer) data_q <= in_pyld;
   end else if (MODE == 2) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
      state_t           st, st_nxt;
      logic [WIDTH-1:0] main_q, skid_q;
      logic             in_xfer, out_xfer, ld_main, ld_skid;
      assign in_ready  = st != FULL;
      assign out_valid = st != EMPTY;
      assign out_pyld  = main_q;
      assign idle      = st == EMPTY;
      assign in_xfer   = in_valid && in_ready;
      assign out_xfer  = out_valid && out_ready;
      always_ff @(posedge slv_aclk or negedge slv_arstn)
         if (!slv_arstn) st <= EMPTY;
         else st <= st_nxt;
      always_comb begin
         st_nxt  = st;
         ld_main = 1'b0;
         ld_skid = 1'b0;
         case (st)
            EMPTY: begin
               st_nxt  = in_xfer ? ONE : EMPTY;
               ld_main = in_xfer;
            end
            ONE: begin
               st_nxt  = (in_xfer && !out_xfer) ? FULL : ((out_xfer && !in_xfer) ? EMPTY : ONE);
               ld_main = in_xfer && out_xfer;
               ld_skid = in_xfer && !out_xfer;
            end
            FULL: begin
               st_nxt  = out_xfer ? ONE : FULL;
               ld_main = out_xfer;
            end
            default: st_nxt = EMPTY;
         endcase
      end
      // In FULL the only reload source for main is the skid beat
      always_ff @(posedge slv_aclk) begin
         if (ld_main) main_q <= (st == FULL) ? skid_q : in_pyld;
         if (ld_skid) skid_q <= in_pyld;
      end
   end else begin : g_illegal
      $error("dwc_pcie_axi_slv_rs_ch: MODE must be 0, 1 or 2");
   end
endmodule

module dwc_pcie_axi_slv_rs #(
   parameter int AW_PYLD_WIDTH = 64,
   parameter int AR_PYLD_WIDTH = 64,
   parameter int W_PYLD_WIDTH  = 145,
   parameter int R_PYLD_WIDTH  = 140,
   parameter int B_PYLD_WIDTH  = 12,
   parameter int AW_MODE       = 2,
   parameter int AR_MODE       = 2,
   parameter int W_MODE        = 2,
   parameter int R_MODE        = 2,
   parameter int B_MODE        = 2
) (
   input  logic                     slv_aclk,
   input  logic                     slv_arstn,
   input  logic                     in_aw_valid,
   input  logic [AW_PYLD_WIDTH-1:0] in_aw_pyld,
   output logic                     in_aw_ready,
   output logic                     out_aw_valid,
   output logic [AW_PYLD_WIDTH-1:0] out_aw_pyld,
   input  logic                     out_aw_ready,
   input  logic                     in_ar_valid,
   input  logic [AR_PYLD_WIDTH-1:0] in_ar_pyld,
   output logic                     in_ar_ready,
   output logic                     out_ar_valid,
   output logic [AR_PYLD_WIDTH-1:0] out_ar_pyld,
   input  logic                     out_ar_ready,
   input  logic                     in_w_valid,
   input  logic [W_PYLD_WIDTH-1:0]  in_w_pyld,
   output logic                     in_w_ready,
   output logic                     out_w_valid,
   output logic [W_PYLD_WIDTH-1:0]  out_w_pyld,
   input  logic                     out_w_ready,
   input  logic                     in_r_valid,
   input  logic [R_PYLD_WIDTH-1:0]  in_r_pyld,
   output logic                     in_r_ready,
   output logic                     out_r_valid,
   output logic [R_PYLD_WIDTH-1:0]  out_r_pyld,
   input  logic                     out_r_ready,
   input  logic                     in_b_valid,
   input  logic [B_PYLD_WIDTH-1:0]  in_b_pyld,
   output logic                     in_b_ready,
   output logic                     out_b_valid,
   output logic [B_PYLD_WIDTH-1:0]  out_b_pyld,
   input  logic                     out_b_ready,
   output logic                     slice_idle
);
   logic aw_idle, ar_idle, w_idle, r_idle, b_idle;

   dwc_pcie_axi_slv_rs_ch #(.WIDTH(AW_PYLD_WIDTH), .MODE(AW_MODE)) u_aw (
      .slv_aclk, .slv_arstn,
      .in_valid(in_aw_valid), .in_pyld(in_aw_pyld), .in_ready(in_aw_ready),
      .out_valid(out_aw_valid), .out_pyld(out_aw_pyld), .out_ready(out_aw_ready),
      .idle(aw_idle));

   dwc_pcie_axi_slv_rs_ch #(.WIDTH(AR_PYLD_WIDTH), .MODE(AR_MODE)) u_ar (
      .slv_aclk, .slv_arstn,
      .in_valid(in_ar_valid), .in_pyld(in_ar_pyld), .in_ready(in_ar_ready),
      .out_valid(out_ar_valid), .out_pyld(out_ar_pyld), .out_ready(out_ar_ready),
      .idle(ar_idle));

   dwc_pcie_axi_slv_rs_ch #(.WIDTH(W_PYLD_WIDTH), .MODE(W_MODE)) u_w (
      .slv_aclk, .slv_arstn,
      .in_valid(in_w_valid), .in_pyld(in_w_pyld), .in_ready(in_w_ready),
      .out_valid(out_w_valid), .out_pyld(out_w_pyld), .out_ready(out_w_ready),
      .idle(w_idle));

   dwc_pcie_axi_slv_rs_ch #(.WIDTH(R_PYLD_WIDTH), .MODE(R_MODE)) u_r (
      .slv_aclk, .slv_arstn,
      .in_valid(in_r_valid), .in_pyld(in_r_pyld), .in_ready(in_r_ready),
      .out_valid(out_r_valid), .out_pyld(out_r_pyld), .out_ready(out_r_ready),
      .idle(r_idle));

   dwc_pcie_axi_slv_rs_ch #(.WIDTH(B_PYLD_WIDTH), .MODE(B_MODE)) u_b (
      .slv_aclk, .slv_arstn,
      .in_valid(in_b_valid), .in_pyld(in_b_pyld), .in_ready(in_b_ready),
      .out_valid(out_b_valid), .out_pyld(out_b_pyld), .out_ready(out_b_ready),
      .idle(b_idle));

   assign slice_idle = aw_idle && ar_idle && w_idle && r_idle && b_idle;
endmodule

// File: tb/tb_dwc_pcie_axi_slv_rs.sv
// tb_dwc_pcie_axi_slv_rs: directed checks of the slave-port register slice
// (AW mode 1, AR/W/R mode 2, B bypass).
module tb_dwc_pcie_axi_slv_rs;
   logic          slv_aclk = 1'b0;
   logic          slv_arstn;
   logic          in_aw_valid, in_aw_ready, out_aw_valid, out_aw_ready;
   logic [63:0]   in_aw_pyld, out_aw_pyld;
   logic          in_ar_valid, in_ar_ready, out_ar_valid, out_ar_ready;
   logic [63:0]   in_ar_pyld, out_ar_pyld;
   logic          in_w_valid, in_w_ready, out_w_valid, out_w_ready;
   logic [144:0]  in_w_pyld, out_w_pyld;
   logic          in_r_valid, in_r_ready, out_r_valid, out_r_ready;
   logic [139:0]  in_r_pyld, out_r_pyld;
   logic          in_b_valid, in_b_ready, out_b_valid, out_b_ready;
   logic [11:0]   in_b_pyld, out_b_pyld;
   logic          slice_idle;
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 slv_aclk = ~slv_aclk;

   dwc_pcie_axi_slv_rs #(
      .AW_MODE(1), .AR_MODE(2), .W_MODE(2), .R_MODE(2), .B_MODE(0)
   ) dut (
      .slv_aclk(slv_aclk), .slv_arstn(slv_arstn),
      .in_aw_valid(in_aw_valid), .in_aw_pyld(in_aw_pyld), .in_aw_ready(in_aw_ready),
      .out_aw_valid(out_aw_valid), .out_aw_pyld(out_aw_pyld), .out_aw_ready(out_aw_ready),
      .in_ar_valid(in_ar_valid), .in_ar_pyld(in_ar_pyld), .in_ar_ready(in_ar_ready),
      .out_ar_valid(out_ar_valid), .out_ar_pyld(out_ar_pyld), .out_ar_ready(out_ar_ready),
      .in_w_valid(in_w_valid), .in_w_pyld(in_w_pyld), .in_w_ready(in_w_ready),
      .out_w_valid(out_w_valid), .out_w_pyld(out_w_pyld), .out_w_ready(out_w_ready),
      .in_r_valid(in_r_valid), .in_r_pyld(in_r_pyld), .in_r_ready(in_r_ready),
      .out_r_valid(out_r_valid), .out_r_pyld(out_r_pyld), .out_r_ready(out_r_ready),
      .in_b_valid(in_b_valid), .in_b_pyld(in_b_pyld), .in_b_ready(in_b_ready),
      .out_b_valid(out_b_valid), .out_b_pyld(out_b_pyld), .out_b_ready(out_b_ready),
      .slice_idle(slice_idle)
   );

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs driven here, then #1 before checking
   task automatic tick;
      @(posedge slv_aclk);
      #1;
   endtask

   initial begin
      int got_n, sent, c;
      int in_cnt, out_cnt;
      slv_arstn = 1'b0;
      {in_aw_valid, in_ar_valid, in_w_valid, in_r_valid, in_b_valid} = '1;
      {out_aw_ready, out_ar_ready, out_w_ready, out_r_ready, out_b_ready} = '0;
      in_aw_pyld = 64'h1; in_ar_pyld = 64'h2; in_w_pyld = '0; in_r_pyld = '0; in_b_pyld = '0;
      tick; tick;
      #1;
      chk("rst_aw_valid", out_aw_valid, 0);
      chk("rst_ar_valid", out_ar_valid, 0);
      chk("rst_w_valid", out_w_valid, 0);
      chk("rst_r_valid", out_r_valid, 0);
      chk("rst_aw_ready", in_aw_ready, 1);
      chk("rst_ar_ready", in_ar_ready, 1);
      chk("rst_w_ready", in_w_ready, 1);
      chk("rst_r_ready", in_r_ready, 1);
      chk("rst_idle", slice_idle, 1);
      {in_aw_valid, in_ar_valid, in_w_valid, in_r_valid, in_b_valid} = '0;
      #1 slv_arstn = 1'b1;
      tick;
      #1;
      chk("rel_w_valid", out_w_valid, 0);
      chk("rel_aw_valid", out_aw_valid, 0);
      chk("rel_idle", slice_idle, 1);

      // Streaming on W with sink always ready
      out_w_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         in_w_valid = i < 16;
         in_w_pyld  = 145'(i);
         #1;
         if (i == 0) chk("str_first_valid", out_w_valid, 0);
         if (i >= 1 && i <= 16) begin
            chk($sformatf("str_valid%0d", i), out_w_valid, 1);
            chk($sformatf("str_pyld%0d", i), out_w_pyld, 160'(i - 1));
            chk($sformatf("str_idle%0d", i), slice_idle, 0);
         end
         if (i < 16) chk($sformatf("str_ready%0d", i), in_w_ready, 1);
         tick;
      end
      chk("str_end_valid", out_w_valid, 0);

      // Backpressure on W: sink stalls for cycles 3..6
      got_n = 0; sent = 0; c = 0;
      while (got_n < 16 && c < 60) begin
         in_w_valid  = sent < 16;
         in_w_pyld   = 145'(8'h10 + sent);
         out_w_ready = !(c >= 3 && c < 7);
         #1;
         if (c == 3) chk("bp_ready_c3", in_w_ready, 1);
         if (c == 4 || c == 6) begin
            chk($sformatf("bp_ready_c%0d", c), in_w_ready, 0);
            chk($sformatf("bp_main_c%0d", c), out_w_pyld, 160'h12);
            chk($sformatf("bp_valid_c%0d", c), out_w_valid, 1);
         end
         if (c == 8) chk("bp_ready_c8", in_w_ready, 1);
         if (out_w_valid && out_w_ready) begin
            chk($sformatf("bp_beat%0d", got_n), out_w_pyld, 160'(8'h10 + got_n));
            got_n++;
         end
         if (in_w_valid && in_w_ready) sent++;
         tick;
         c++;
      end
      chk("bp_count", 160'(got_n), 160'd16);
      in_w_valid = 1'b0;
      tick;

      // Mode 1 on AW: simultaneous in and out transfer
      in_aw_valid = 1'b1; in_aw_pyld = 64'hA; out_aw_ready = 1'b0;
      tick;
      in_aw_pyld = 64'hB;
      #1;
      chk("m1_stall_ready", in_aw_ready, 0);
      chk("m1_hold_pyld", out_aw_pyld, 160'hA);
      out_aw_ready = 1'b1;
      #1;
      chk("m1_ready_comb", in_aw_ready, 1);
      chk("m1_out_a_valid", out_aw_valid, 1);
      chk("m1_out_a_pyld", out_aw_pyld, 160'hA);
      tick;
      in_aw_valid = 1'b0;
      #1;
      chk("m1_out_b_valid", out_aw_valid, 1);
      chk("m1_out_b_pyld", out_aw_pyld, 160'hB);
      tick;
      #1;
      chk("m1_drain_valid", out_aw_valid, 0);
      out_aw_ready = 1'b0;

      // Bypass on B with random handshakes
      in_cnt = 0; out_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         in_b_valid  = 1'($urandom_range(0, 1));
         out_b_ready = 1'($urandom_range(0, 1));
         in_b_pyld   = 12'($urandom);
         #1;
         chk("byp_valid", out_b_valid, in_b_valid);
         chk("byp_pyld", out_b_pyld, in_b_pyld);
         chk("byp_ready", in_b_ready, out_b_ready);
         in_cnt  += int'(in_b_valid && in_b_ready);
         out_cnt += int'(out_b_valid && out_b_ready);
         tick;
      end
      chk("byp_counts", 160'(out_cnt), 160'(in_cnt));
      in_b_valid = 1'b0;

      // Reset while AR holds two beats
      out_ar_ready = 1'b0;
      in_ar_valid = 1'b1; in_ar_pyld = 64'h5;
      tick;
      in_ar_pyld = 64'h6;
      tick;
      in_ar_valid = 1'b0;
      #1;
      chk("ar_full_ready", in_ar_ready, 0);
      chk("ar_full_pyld", out_ar_pyld, 160'h5);
      chk("ar_full_idle", slice_idle, 0);
      #1 slv_arstn = 1'b0;
      #1;
      chk("ar_rst_valid", out_ar_valid, 0);
      chk("ar_rst_ready", in_ar_ready, 1);
      chk("ar_rst_idle", slice_idle, 1);
      tick;
      #1 slv_arstn = 1'b1;
      out_ar_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("ar_post_valid%0d", i), out_ar_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
